// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg_if
// Description : Serial-in / byte-out bundle of the configurable UART receiver.
//               Signal names keep their direction prefixes as seen from the
//               receiver, so the slave modport is the receiver itself and the
//               master modport is the board/consumer side.
// Ports       : i_RX_Serial  - serial line into the receiver (idle high)
//               o_RX_DV      - one-cycle frame-complete strobe
//               o_RX_Data    - received word, LSB = first data bit
//               o_Parity_Err - parity mismatch of the last frame
//               o_Frame_Err  - a stop-bit sample was low in the last frame
//               o_Busy       - receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_RX_Serial;
  logic                 o_RX_DV;
  logic [DATA_BITS-1:0] o_RX_Data;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Busy;

  modport slave (
    input  i_RX_Serial,
    output o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Busy
  );

  modport master (
    output i_RX_Serial,
    input  o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Parametrised UART receiver. Configurable data width, parity
//               mode and stop-bit count; 2-flop input synchroniser; parity
//               and framing error flags. The frame completes at the middle of
//               the last stop bit so back-to-back frames need no idle gap.
//               Optional macro UART_RX_CFG_MAJORITY_EN: every bit sample is
//               the majority of the last three synchronised line values.
// Ports       : i_Clock - clock, all logic on the rising edge
//               i_Reset - synchronous active-high reset
//               rx      - uart_rx_cfg_if.slave (serial in, data/flags out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  wire logic    i_Clock,
  input  wire logic    i_Reset,
  uart_rx_cfg_if.slave rx
);

  localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF  = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]         c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]         c_STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit                 c_HAS_PAR   = (PARITY != 0);
  localparam logic               c_PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_DONE      = 3'd5,
    S_WAIT_HIGH = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser (reset to the idle level so reset never looks like a
  // start bit)
  // --------------------------------------------------------------------------
  logic r_sync_meta;
  logic r_sync_line;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_sync_meta <= 1'b1;
      r_sync_line <= 1'b1;
    end else begin
      r_sync_meta <= rx.i_RX_Serial;
      r_sync_line <= r_sync_meta;
    end
  end

  // w_sample is what the FSM latches at each bit sample point. Start-edge
  // detection in IDLE and the release check in WAIT_HIGH use the plain
  // synchronised line.
  logic w_sample;

`ifdef UART_RX_CFG_MAJORITY_EN
  // Window = current synchronised value plus two older ones, centred one
  // cycle before the nominal sample point.
  logic [1:0] r_hist;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_sync_line};
    end
  end

  assign w_sample = (r_sync_line & r_hist[0]) |
                    (r_sync_line & r_hist[1]) |
                    (r_hist[0]   & r_hist[1]);
`else
  assign w_sample = r_sync_line;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic [3:0]         r_idx;
  logic [3:0]         w_idx_next;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and datapath strobes
  // --------------------------------------------------------------------------
  logic w_bit_end;
  logic w_shift_en;
  logic w_par_en;
  logic w_stop_en;
  logic w_load_out;
  logic r_frame_err;

  assign w_bit_end = (r_cnt == c_CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_idx_next   = r_idx;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_stop_en    = 1'b0;
    w_load_out   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_idx_next = '0;
        if (!r_sync_line) begin
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (r_cnt == c_CNT_HALF) begin
          // A high line at mid-start is a glitch: drop it silently.
          w_state_next = w_sample ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_shift_en = 1'b1;
          if (r_idx == c_DATA_LAST) begin
            w_idx_next   = '0;
            w_state_next = c_HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_par_en     = 1'b1;
          w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_stop_en = 1'b1;
          if (r_idx == c_STOP_LAST) begin
            // Finish at the last stop sample; the rest of the stop bit is
            // not waited for, which leaves room for a back-to-back start.
            w_idx_next   = '0;
            w_load_out   = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_DONE: begin
        // A framing error may mean a held-low break; wait for the line to
        // return high before looking for another start bit.
        w_state_next = r_frame_err ? S_WAIT_HIGH : S_IDLE;
      end

      S_WAIT_HIGH: begin
        if (r_sync_line) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, parity/stop capture and held outputs
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_bit;
  logic                 r_frame_pend;
  logic                 r_par_err;
  logic                 w_par_err;

  // Odd parity: data XOR parity bit must be 1; even: must be 0.
  assign w_par_err = c_HAS_PAR && ((^r_shift ^ r_par_bit) != c_PAR_ODD);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_shift      <= '0;
      r_data       <= '0;
      r_par_bit    <= 1'b0;
      r_frame_pend <= 1'b0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      // LSB arrives first, so shift in from the top.
      if (w_shift_en) begin
        r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
      end

      if (w_par_en) begin
        r_par_bit <= w_sample;
      end

      if (r_state == S_START) begin
        r_frame_pend <= 1'b0;
      end else if (w_stop_en && !w_sample) begin
        r_frame_pend <= 1'b1;
      end

      // The last stop sample is folded in directly since it is not yet in
      // r_frame_pend.
      if (w_load_out) begin
        r_data      <= r_shift;
        r_par_err   <= w_par_err;
        r_frame_err <= r_frame_pend | ~w_sample;
      end
    end
  end

  assign rx.o_RX_DV      = (r_state == S_DONE);
  assign rx.o_RX_Data    = r_data;
  assign rx.o_Parity_Err = r_par_err;
  assign rx.o_Frame_Err  = r_frame_err;
  assign rx.o_Busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Self-checking bench for uart_rx_cfg. Three receivers share a
//               clock and reset: A = 8N1, B = 7 data bits even parity,
//               C = 8 data bits 2 stop bits, all at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

  localparam int CPB = 16;
  localparam int H   = (CPB - 1) / 2;

`ifdef UART_RX_CFG_MAJORITY_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ser [3];
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_c ();

  assign if_a.i_RX_Serial = ser[0];
  assign if_b.i_RX_Serial = ser[1];
  assign if_c.i_RX_Serial = ser[2];

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .i_Clock(clk), .i_Reset(rst), .rx(if_a.slave));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut_b (
    .i_Clock(clk), .i_Reset(rst), .rx(if_b.slave));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_c (
    .i_Clock(clk), .i_Reset(rst), .rx(if_c.slave));

  // Every DV cycle seen on each receiver, captured on the falling edge.
  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  data;
    logic        pe;
    logic        fe;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t q_c[$];

  always @(negedge clk) begin
    if (if_a.o_RX_DV === 1'b1)
      q_a.push_back(ev_t'({32'(cyc), 9'(if_a.o_RX_Data), if_a.o_Parity_Err, if_a.o_Frame_Err}));
    if (if_b.o_RX_DV === 1'b1)
      q_b.push_back(ev_t'({32'(cyc), 9'(if_b.o_RX_Data), if_b.o_Parity_Err, if_b.o_Frame_Err}));
    if (if_c.o_RX_DV === 1'b1)
      q_c.push_back(ev_t'({32'(cyc), 9'(if_c.o_RX_Data), if_c.o_Parity_Err, if_c.o_Frame_Err}));
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic ev_t qpop(input int idx);
    case (idx)
      0:       return q_a.pop_front();
      1:       return q_b.pop_front();
      default: return q_c.pop_front();
    endcase
  endfunction

  // Reference frame: start 0, data LSB first, optional parity, stop bits.
  function automatic logic [15:0] build(input logic [8:0] d, input int nd, input bit has_par,
                                        input logic pb, input logic [1:0] stops, input int ns);
    logic [15:0] f;
    int p;
    f = '1;
    f[0] = 1'b0;
    p = 1;
    for (int i = 0; i < nd; i++) begin f[p] = d[i]; p++; end
    if (has_par) begin f[p] = pb; p++; end
    for (int i = 0; i < ns; i++) begin f[p] = stops[i]; p++; end
    return f;
  endfunction

  // Line goes low at bench cycle t; two synchroniser cycles later is t0, and
  // DV follows at t0 + 2 + H + N*CPB with N bits after the start bit.
  function automatic int exp_dv(input int t, input int n);
    return t + 2 + 2 + H + n * CPB;
  endfunction

  // Drive nbits of a frame, one bit per CPB cycles, starting at a falling
  // edge. Optionally inverts the line for one cycle at the nominal sample
  // point of bits glo..ghi. Stops early after max_cycles cycles.
  task automatic drive_frame(input int idx, input logic [15:0] bits, input int nbits,
                             input int glo, input int ghi, input int max_cycles,
                             output int t_start);
    int n;
    n = 0;
    t_start = cyc;
    for (int j = 0; j < nbits; j++) begin
      for (int c = 0; c < CPB; c++) begin
        if (n == max_cycles) return;
        ser[idx] = (GLITCH && j >= glo && j <= ghi && c == H + 1) ? ~bits[j] : bits[j];
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic expect_ev(input int idx, input string tag, input int exp_cyc,
                           input logic [8:0] exp_d, input logic exp_pe, input logic exp_fe,
                           output int obs_cyc);
    ev_t e;
    int  waited;
    waited = 0;
    obs_cyc = -1;
    while (qsize(idx) == 0 && waited < 4 * CPB) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_dv_seen"}, 32'(qsize(idx) != 0), 32'd1);
    if (qsize(idx) != 0) begin
      e = qpop(idx);
      obs_cyc = int'(e.cyc);
      check({tag, "_dv_cycle"}, e.cyc, 32'(exp_cyc));
      check({tag, "_data"}, 32'(e.data), 32'(exp_d));
      check({tag, "_parity_err"}, 32'(e.pe), 32'(exp_pe));
      check({tag, "_frame_err"}, 32'(e.fe), 32'(exp_fe));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          t, t2, oc, oc2, gap;
    logic [7:0]  d8, a_last;
    logic [6:0]  d7;
    logic        pb;
    logic [1:0]  st;

    ser[0] = 1'b1; ser[1] = 1'b1; ser[2] = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check("rst_a_busy", 32'(if_a.o_Busy), 32'd0);
    check("rst_a_dv", 32'(if_a.o_RX_DV), 32'd0);
    check("rst_a_data", 32'(if_a.o_RX_Data), 32'd0);
    check("rst_a_pe", 32'(if_a.o_Parity_Err), 32'd0);
    check("rst_a_fe", 32'(if_a.o_Frame_Err), 32'd0);
    check("rst_b_busy", 32'(if_b.o_Busy), 32'd0);
    check("rst_c_busy", 32'(if_c.o_Busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // ---- 8N1 0xA5 latency and single-cycle DV ----
    drive_frame(0, build(9'h0A5, 8, 0, 1'b0, 2'b11, 1), 10, 1, 0, 1 << 20, t);
    expect_ev(0, "a5", exp_dv(t, 9), 9'h0A5, 1'b0, 1'b0, oc);
    check("a5_busy_after", 32'(if_a.o_Busy), 32'd0);
    check("a5_single_dv", 32'(q_a.size()), 32'd0);
    a_last = 8'hA5;

    // ---- back-to-back 0x01 then 0xFF, glitches at data samples if enabled ----
    drive_frame(0, build(9'h001, 8, 0, 1'b0, 2'b11, 1), 10, 1, 8, 1 << 20, t);
    drive_frame(0, build(9'h0FF, 8, 0, 1'b0, 2'b11, 1), 10, 1, 8, 1 << 20, t2);
    expect_ev(0, "b2b_1", exp_dv(t, 9), 9'h001, 1'b0, 1'b0, oc);
    expect_ev(0, "b2b_2", exp_dv(t2, 9), 9'h0FF, 1'b0, 1'b0, oc2);
    check("b2b_spacing", 32'(oc2 - oc), 32'(10 * CPB));
    a_last = 8'hFF;
    repeat (5) @(negedge clk);

    // ---- short low glitch shorter than half a bit ----
    t = cyc;
    ser[0] = 1'b0;
    repeat (4) @(negedge clk);
    ser[0] = 1'b1;
    check("glitch_busy_mid", 32'(if_a.o_Busy), 32'd1);
    repeat (t + 4 + H + 0 - cyc) @(negedge clk);
    check("glitch_busy_cleared", 32'(if_a.o_Busy), 32'd0);
    check("glitch_no_dv", 32'(q_a.size()), 32'd0);
    check("glitch_data_held", 32'(if_a.o_RX_Data), 32'(a_last));
    repeat (10) @(negedge clk);

    // ---- reset during data bit 3 of 0xF0 ----
    drive_frame(0, build(9'h0F0, 8, 0, 1'b0, 2'b11, 1), 10, 1, 0, 4 * CPB + 6, t);
    ser[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(if_a.o_Busy), 32'd0);
    check("mid_rst_data", 32'(if_a.o_RX_Data), 32'd0);
    check("mid_rst_flags", 32'({if_a.o_Parity_Err, if_a.o_Frame_Err}), 32'd0);
    check("mid_rst_dv", 32'(if_a.o_RX_DV), 32'd0);
    repeat (3 * CPB) @(negedge clk);
    check("mid_rst_no_dv", 32'(q_a.size()), 32'd0);
    drive_frame(0, build(9'h03C, 8, 0, 1'b0, 2'b11, 1), 10, 1, 0, 1 << 20, t);
    expect_ev(0, "after_rst", exp_dv(t, 9), 9'h03C, 1'b0, 1'b0, oc);

    // ---- random 8N1 frames with small random idle gaps ----
    for (int i = 0; i < 5; i++) begin
      d8 = 8'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      drive_frame(0, build({1'b0, d8}, 8, 0, 1'b0, 2'b11, 1), 10, 1, 0, 1 << 20, t);
      expect_ev(0, "rand_a", exp_dv(t, 9), {1'b0, d8}, 1'b0, 1'b0, oc);
    end

    // ---- 7E1: wrong then right parity bit ----
    drive_frame(1, build(9'h055, 7, 1, 1'b1, 2'b11, 1), 10, 1, 0, 1 << 20, t);
    expect_ev(1, "par_bad", exp_dv(t, 9), 9'h055, 1'b1, 1'b0, oc);
    repeat (20) @(negedge clk);
    check("par_err_held", 32'(if_b.o_Parity_Err), 32'd1);
    check("par_data_held", 32'(if_b.o_RX_Data), 32'h55);
    drive_frame(1, build(9'h055, 7, 1, 1'b0, 2'b11, 1), 10, 1, 0, 1 << 20, t);
    expect_ev(1, "par_good", exp_dv(t, 9), 9'h055, 1'b0, 1'b0, oc);

    for (int i = 0; i < 5; i++) begin
      d7 = 7'($urandom);
      pb = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drive_frame(1, build({2'b0, d7}, 7, 1, pb, 2'b11, 1), 10, 1, 0, 1 << 20, t);
      expect_ev(1, "rand_b", exp_dv(t, 9), {2'b0, d7}, 1'(($countones(d7) + pb) % 2), 1'b0, oc);
    end

    // ---- 8N2: second stop bit low, then a 40-bit-time break ----
    drive_frame(2, build(9'h03C, 8, 0, 1'b0, 2'b01, 2), 11, 1, 0, 1 << 20, t);
    repeat (40 * CPB) @(negedge clk);
    expect_ev(2, "break", exp_dv(t, 10), 9'h03C, 1'b0, 1'b1, oc);
    check("break_one_dv", 32'(q_c.size()), 32'd0);
    check("break_busy", 32'(if_c.o_Busy), 32'd1);
    ser[2] = 1'b1;
    repeat (CPB) @(negedge clk);
    drive_frame(2, build(9'h081, 8, 0, 1'b0, 2'b11, 2), 11, 1, 0, 1 << 20, t);
    expect_ev(2, "post_break", exp_dv(t, 10), 9'h081, 1'b0, 1'b0, oc);

    for (int i = 0; i < 4; i++) begin
      d8 = 8'($urandom);
      st = 2'($urandom);
      repeat ($urandom_range(4, 6)) @(negedge clk);
      drive_frame(2, build({1'b0, d8}, 8, 0, 1'b0, st, 2), 11, 1, 0, 1 << 20, t);
      expect_ev(2, "rand_c", exp_dv(t, 10), {1'b0, d8}, 1'b0, ~(st[0] & st[1]), oc);
      ser[2] = 1'b1;
    end

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
